pe_pipe_adder: RTL and testbench
================================

# pe_pipe_adder

Parametrised, pipelined two-operand integer adder/subtractor for the PE coprocessor's fused multiply-add datapath. It builds on the half/full-adder cell primitives. The WIDTH-bit carry chain is cut into SEG-bit segments, one segment resolved per pipeline stage, so wide additions close timing at full clock rate. A valid/ready handshake on both sides gives full throughput (one operation per cycle) with backpressure.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of SEG.
- SEG, 8: segment width; NSTG = WIDTH/SEG pipeline stages (NSTG ≥ 1).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (ignored when in_sub=1).
- in_sub  in  1  0: A+B+cin; 1: A−B (A + ~B + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- out_ovf  out  1  two's-complement signed overflow.

## Operation
- Accept when in_valid && in_ready. Effective B' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
- Stage k (0..NSTG−1) computes segment k: {c(k+1), s_k} = A_k + B'_k + c_k, with c_k from stage k−1's register. Unprocessed upper segments travel down as skew registers; completed lower sum segments travel with them.
- Last stage registers out_sum, out_cout = c(NSTG), and out_ovf = c(NSTG) XOR carry into MSB bit. Equivalently: signs of A and B' equal, sign of sum differs.
- No operation mode or state beyond per-stage valid bits. Results leave in strict acceptance order.
- Backpressure: stage k loads when !valid[k] || advance[k+1]. The output stage advances when !out_valid || out_ready. in_ready = stage-0 load condition. The pipeline compresses bubbles: a stalled tail does not block empty upstream stages.
- Simultaneous accept and emit in one cycle is legal and sustains 1 op/cycle.
- Data outputs hold their value while out_valid && !out_ready. They are don't-care when out_valid=0 but must not be X after reset.

## Timing
- Latency: NSTG cycles from accept edge to out_valid high (WIDTH=32, SEG=8 → 4). NSTG=1 → 1 cycle.
- Throughput: 1 result/cycle with out_ready held high.
- Capacity: NSTG in-flight ops. in_ready falls only when all stages are valid and out_ready=0.
- in_ready is combinational from out_ready and the valid bits. There is no combinational path from in_* to out_*.
- Reset (async assert): all valid bits 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0. in_ready is 1 in the first cycle after deassert.
- Reset mid-operation: all in-flight operations are discarded, with no partial output.
- Reset deassertion is synchronised externally; the block needs no extra handling.

## Structure
- Shared package pe_arith_pkg holds:
  - localparam OP_ADD=1'b0, OP_SUB=1'b1
  - a helper function computing NSTG from WIDTH/SEG
- A static check errors on WIDTH % SEG != 0.
- Sub-module pe_seg_stage: one pipeline stage. It holds the SEG-bit ripple adder built from the existing FA/HA cells (or `+`), carry register, skew/sum registers and valid/advance logic. It is generated NSTG times.
- The top level wires the handshake chain, computes ovf, and drives the outputs.

## Test plan
- Reset then single add, WIDTH=32 SEG=8: A=0x0000_00FF, B=0x0000_0001, cin=0 → after 4 cycles sum=0x0000_0100, cout=0, ovf=0; the carry ripples across a segment boundary.
- Full carry chain: A=0xFFFF_FFFF, B=0, cin=1 → sum=0, cout=1, ovf=0. Subtract A=5, B=7 → sum=0xFFFF_FFFE, cout=0.
- Signed overflow: A=0x7FFF_FFFF + B=1 → sum=0x8000_0000, ovf=1. Subtract A=0x8000_0000 − 1 → 0x7FFF_FFFF, ovf=1.
- Backpressure: stream 10 random ops with out_ready low for cycles 3–8 → in_ready falls after 4 outstanding, no loss or reorder, outputs hold stable. With ready high, 10 results arrive in 10 consecutive cycles and match the reference model.
- Async reset asserted with 3 ops in flight → out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and the first new op emerges 4 cycles after accept.
- Parameter sweep (WIDTH,SEG) = (8,8), (16,4), (64,16) → 1000 random ops each match a golden A±B model with latency NSTG.

Source files
------------

// File: rtl/pe_arith_pkg.sv
// Shared arithmetic definitions for the PE coprocessor datapath: operation
// encodings and pipeline depth derivation for the segmented adder.
package pe_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_nstg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pe_seg_stage.sv
// One pipeline stage of the segmented adder: resolves segment IDX of the sum
// and carries the still-unprocessed operand bits forward with the partial sum.
module pe_seg_stage
  import pe_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_sum,
  input  logic             up_c,
  output logic             valid,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             c
);

  localparam int LO = IDX * SEG;

  logic [SEG:0]       seg_res;
  logic [WIDTH-1:0]   sum_next;

  always_comb begin
    seg_res  = {1'b0, up_a[LO +: SEG]} + {1'b0, up_b[LO +: SEG]} + {{SEG{1'b0}}, up_c};
    sum_next = up_sum;
    sum_next[LO +: SEG] = seg_res[SEG-1:0];
  end

  // Data only changes on a real transfer, so a stalled result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      a     <= '0;
      b     <= '0;
      sum   <= '0;
      c     <= 1'b0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        a   <= up_a;
        b   <= up_b;
        sum <= sum_next;
        c   <= seg_res[SEG];
      end
    end
  end

endmodule

// File: rtl/pe_pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor, one SEG-bit carry segment per stage,
// with valid/ready handshaking and bubble compression on both sides.
module pe_pipe_adder
  import pe_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSTG = calc_nstg(WIDTH, SEG);

  generate
    if (WIDTH % SEG != 0) begin : g_bad_width
      $error("pe_pipe_adder: WIDTH must be a multiple of SEG");
    end
  endgenerate

  // Index 0 is the input port side; index k+1 is the register of stage k.
  logic [WIDTH-1:0] a_s   [NSTG+1];
  logic [WIDTH-1:0] b_s   [NSTG+1];
  logic [WIDTH-1:0] sum_s [NSTG+1];
  logic [NSTG:0]    valid_s;
  logic [NSTG:0]    c_s;
  logic [NSTG-1:0]  load;
  logic             acc;
  logic             unused_bits;

  assign valid_s[0] = in_valid;
  assign a_s[0]     = in_a;
  assign b_s[0]     = (in_sub == OP_ADD) ? in_b : ~in_b;
  assign sum_s[0]   = '0;
  assign c_s[0]     = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  // A stage may load if it or any stage downstream of it has a free slot,
  // unrolled from the output so no combinational loop is formed.
  always_comb begin
    load = '0;
    acc  = out_ready;
    for (int k = NSTG - 1; k >= 0; k--) begin
      acc     = acc || !valid_s[k+1];
      load[k] = acc;
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < NSTG; k++) begin : g_stage
    pe_seg_stage #(
      .WIDTH(WIDTH),
      .SEG  (SEG),
      .IDX  (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[k]),
      .up_valid(valid_s[k]),
      .up_a    (a_s[k]),
      .up_b    (b_s[k]),
      .up_sum  (sum_s[k]),
      .up_c    (c_s[k]),
      .valid   (valid_s[k+1]),
      .a       (a_s[k+1]),
      .b       (b_s[k+1]),
      .sum     (sum_s[k+1]),
      .c       (c_s[k+1])
    );
  end

  assign out_valid = valid_s[NSTG];
  assign out_sum   = sum_s[NSTG];
  assign out_cout  = c_s[NSTG];
  assign out_ovf   = (a_s[NSTG][WIDTH-1] == b_s[NSTG][WIDTH-1]) &&
                     (sum_s[NSTG][WIDTH-1] != a_s[NSTG][WIDTH-1]);

  // Only the operand sign bits are needed past the last stage.
  assign unused_bits = ^{a_s[NSTG][WIDTH-2:0], b_s[NSTG][WIDTH-2:0]};

endmodule

// File: tb/tb_pe_pipe_adder.sv
// Scoreboard bench for pe_pipe_adder (WIDTH=32, SEG=8): directed corner cases,
// throughput, backpressure, mid-flight reset and a randomized handshake run.
module tb_pe_pipe_adder;

  localparam int W    = 32;
  localparam int SEG  = 8;
  localparam int NSTG = W / SEG;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   pop_times[$];

  logic         held;
  logic [W-1:0] held_sum;
  logic         held_cout;
  logic         held_ovf;

  pe_pipe_adder #(.WIDTH(W), .SEG(SEG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: unsigned result modulo 2^W, carry/no-borrow, and signed range test.
  function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, input logic sub);
    exp_t   e;
    longint sres;
    logic [W:0] wide;
    if (sub) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      sres   = longint'($signed(a)) - longint'($signed(b));
    end else begin
      wide   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum  = wide[W-1:0];
      e.cout = wide[W];
      sres   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    end
    e.ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
    return e;
  endfunction

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input logic vld);
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = vld;
  endtask

  // Monitor: records accepted beats, checks emitted results and stall stability.
  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
          if (out_valid)
            checkOutput("hold_data", {out_sum, out_cout, out_ovf}, {held_sum, held_cout, held_ovf});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got sum 0x%0h with no operation outstanding", out_sum);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sb_sum", {32'd0, out_sum}, {32'd0, e.sum});
            checkOutput("sb_cout", {63'd0, out_cout}, {63'd0, e.cout});
            checkOutput("sb_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
            pop_times.push_back(cyc);
          end
        end
        held      = out_valid && !out_ready;
        held_sum  = out_sum;
        held_cout = out_cout;
        held_ovf  = out_ovf;
        if (in_valid && in_ready)
          sb.push_back(refModel(in_a, in_b, in_cin, in_sub));
      end
    end
  end

  // Single op on an empty pipe: latency counted from the cycle it is presented.
  task automatic timedOp(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic [W-1:0] exp_sum,
                         input logic exp_cout, input logic exp_ovf);
    int lat;
    lat = 0;
    out_ready = 1'b1;
    applyStimulus(a, b, cin, sub, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    checkOutput({name, "_latency"}, lat, NSTG);
    checkOutput({name, "_sum"}, {32'd0, out_sum}, {32'd0, exp_sum});
    checkOutput({name, "_cout"}, {63'd0, out_cout}, {63'd0, exp_cout});
    checkOutput({name, "_ovf"}, {63'd0, out_ovf}, {63'd0, exp_ovf});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput(name, sb.size(), 0);
  endtask

  initial begin
    int idx;
    int bad_gaps;
    logic saw_stall;
    logic [W-1:0] bp_a [10];
    logic [W-1:0] bp_b [10];
    logic         bp_c [10];
    logic         bp_s [10];

    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_out_sum", {32'd0, out_sum}, 64'd0);
    checkOutput("reset_out_cout", {63'd0, out_cout}, 64'd0);
    checkOutput("reset_out_ovf", {63'd0, out_ovf}, 64'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    $display("[TB] directed corner cases");
    timedOp("seg_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    timedOp("full_chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    timedOp("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    timedOp("sub_cin_ignored", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
    timedOp("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    timedOp("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    $display("[TB] throughput");
    pop_times.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (NSTG + 2) @(posedge clk);
    #1;
    checkOutput("tp_count", pop_times.size(), 10);
    bad_gaps = 0;
    for (int i = 1; i < pop_times.size(); i++)
      if (pop_times[i] - pop_times[i-1] != 1) bad_gaps++;
    checkOutput("tp_consecutive", bad_gaps, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 10; i++) begin
      bp_a[i] = randOperand();
      bp_b[i] = randOperand();
      bp_c[i] = 1'($urandom_range(0, 1));
      bp_s[i] = 1'($urandom_range(0, 1));
    end
    idx = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      out_ready = !(c >= 3 && c <= 8);
      applyStimulus(bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx], 1'b1);
      @(negedge clk);
      if (in_ready) begin
        idx++;
      end else if (!saw_stall) begin
        saw_stall = 1'b1;
        checkOutput("bp_inflight_at_stall", sb.size(), NSTG);
      end
      @(posedge clk);
      #1;
    end
    checkOutput("bp_all_accepted", idx, 10);
    checkOutput("bp_stall_seen", {63'd0, saw_stall}, 64'd1);
    drain("bp_drain_empty");

    $display("[TB] reset with operations in flight");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h1234_5678 + W'(i), 32'h7111_1111, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_pre_out_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    checkOutput("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_mid_out_sum", {32'd0, out_sum}, 64'd0);
    checkOutput("rst_mid_out_cout", {63'd0, out_cout}, 64'd0);
    checkOutput("rst_mid_out_ovf", {63'd0, out_ovf}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    checkOutput("rst_release_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    timedOp("post_reset", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    checkOutput("post_reset_no_stale", {63'd0, out_valid}, 64'd0);

    $display("[TB] randomized handshake run");
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus(randOperand(), randOperand(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0));
      @(posedge clk);
      #1;
    end
    drain("rand_drain_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
